// File: rtl/mem_access_ctrl.sv
// Memory-stage data-bus controller: issues one bus transaction per memory op,
// stalls the pipeline while it is outstanding, and extracts/merges load results.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_ld_kind,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_strobe,
  input  logic [DATA_W-1:0] req_rt_old,
  input  logic              flush,
  output logic              stall,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              addr_err,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic [1:0]        dbg_state
);

  // Bus handshake: dreq_valid rises with every dreq_* field already stable and
  // nothing changes until the cycle dresp_addr_ok is seen; dresp_data_ok may
  // coincide with dresp_addr_ok or follow it, and is honoured once.
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;

  localparam logic [2:0] K_LW  = 3'd0;
  localparam logic [2:0] K_LB  = 3'd1;
  localparam logic [2:0] K_LBU = 3'd2;
  localparam logic [2:0] K_LH  = 3'd3;
  localparam logic [2:0] K_LHU = 3'd4;
  localparam logic [2:0] K_LWL = 3'd5;
  localparam logic [2:0] K_LWR = 3'd6;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [2:0]          kind_q, kind_d;
  logic [1:0]          offs_q, offs_d;
  logic [DATA_W-1:0]   rt_q, rt_d;
  logic                killed_q, killed_d;
  logic                dreq_valid_q, dreq_valid_d;
  logic [ADDR_W-1:0]   dreq_addr_q, dreq_addr_d;
  logic [1:0]          dreq_size_q, dreq_size_d;
  logic [3:0]          dreq_strobe_q, dreq_strobe_d;
  logic [DATA_W-1:0]   dreq_data_q, dreq_data_d;
  logic                result_valid_q, result_valid_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                addr_err_q, addr_err_d;

  logic req_lwlr;
  logic req_misaligned;

  // LWL/LWR are unaligned by design, so they never raise an address error.
  assign req_lwlr       = !req_write && (req_ld_kind == K_LWL || req_ld_kind == K_LWR);
  assign req_misaligned = !req_lwlr &&
                          ((req_size == 2'd1 && req_addr[0]) ||
                           (req_size == 2'd2 && req_addr[1:0] != 2'b00));

  function automatic logic [DATA_W-1:0] extract(input logic [2:0] kind,
                                                input logic [1:0] o,
                                                input logic [DATA_W-1:0] d,
                                                input logic [DATA_W-1:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{o, 3'b000} +: 8];
    h = o[1] ? d[31:16] : d[15:0];
    case (kind)
      K_LB:    extract = {{24{b[7]}}, b};
      K_LBU:   extract = {24'd0, b};
      K_LH:    extract = {{16{h[15]}}, h};
      K_LHU:   extract = {16'd0, h};
      K_LWL: begin
        case (o)
          2'd3:    extract = d;
          2'd2:    extract = {d[23:0], rt[7:0]};
          2'd1:    extract = {d[15:0], rt[15:0]};
          default: extract = {d[7:0], rt[23:0]};
        endcase
      end
      K_LWR: begin
        case (o)
          2'd0:    extract = d;
          2'd1:    extract = {rt[31:24], d[31:8]};
          2'd2:    extract = {rt[31:16], d[31:16]};
          default: extract = {rt[31:8], d[31:24]};
        endcase
      end
      default: extract = d;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    kind_d         = kind_q;
    offs_d         = offs_q;
    rt_d           = rt_q;
    killed_d       = killed_q;
    dreq_valid_d   = dreq_valid_q;
    dreq_addr_d    = dreq_addr_q;
    dreq_size_d    = dreq_size_q;
    dreq_strobe_d  = dreq_strobe_q;
    dreq_data_d    = dreq_data_q;
    result_valid_d = 1'b0;
    result_d       = result_q;
    addr_err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        killed_d = 1'b0;
        if (req_valid && !flush) begin
          write_d       = req_write;
          kind_d        = req_ld_kind;
          offs_d        = req_addr[1:0];
          rt_d          = req_rt_old;
          dreq_addr_d   = req_lwlr ? {req_addr[ADDR_W-1:2], 2'b00} : req_addr;
          dreq_size_d   = req_lwlr ? 2'd2 : req_size;
          dreq_strobe_d = req_write ? req_strobe : 4'd0;
          dreq_data_d   = req_wdata;
          if (req_misaligned) begin
            state_d        = S_DONE;
            result_valid_d = 1'b1;
            addr_err_d     = 1'b1;
            result_d       = '0;
          end else begin
            state_d      = S_ADDR;
            dreq_valid_d = 1'b1;
          end
        end
      end
      S_ADDR, S_DATA: begin
        killed_d = killed_q | flush;
        if (state_q == S_ADDR && dresp_addr_ok) begin
          dreq_valid_d = 1'b0;
          state_d      = S_DATA;
        end
        if ((state_q == S_DATA || dresp_addr_ok) && dresp_data_ok) begin
          state_d        = S_DONE;
          result_valid_d = !killed_d;
          result_d       = write_q ? '0 : extract(kind_q, offs_q, dresp_data, rt_q);
        end
      end
      default: begin
        state_d  = S_IDLE;
        killed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      write_q        <= 1'b0;
      kind_q         <= 3'd0;
      offs_q         <= 2'd0;
      rt_q           <= '0;
      killed_q       <= 1'b0;
      dreq_valid_q   <= 1'b0;
      dreq_addr_q    <= '0;
      dreq_size_q    <= 2'd0;
      dreq_strobe_q  <= 4'd0;
      dreq_data_q    <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      addr_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      write_q        <= write_d;
      kind_q         <= kind_d;
      offs_q         <= offs_d;
      rt_q           <= rt_d;
      killed_q       <= killed_d;
      dreq_valid_q   <= dreq_valid_d;
      dreq_addr_q    <= dreq_addr_d;
      dreq_size_q    <= dreq_size_d;
      dreq_strobe_q  <= dreq_strobe_d;
      dreq_data_q    <= dreq_data_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      addr_err_q     <= addr_err_d;
    end
  end

  assign stall        = (state_q == S_ADDR) || (state_q == S_DATA) ||
                        (state_q == S_IDLE && req_valid);
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign addr_err     = addr_err_q;
  assign dreq_valid   = dreq_valid_q;
  assign dreq_addr    = dreq_addr_q;
  assign dreq_size    = dreq_size_q;
  assign dreq_strobe  = dreq_strobe_q;
  assign dreq_data    = dreq_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl: the bench plays the bus agent
// and checks handshake timing, load extraction, errors, flush and reset.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_ld_kind;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strobe;
  logic [31:0] req_rt_old;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic        addr_err;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] GARBAGE = 32'h5A5A_5A5A;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_ld_kind(req_ld_kind),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_strobe(req_strobe), .req_rt_old(req_rt_old), .flush(flush),
    .stall(stall), .result_valid(result_valid), .result(result), .addr_err(addr_err),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [2:0]  kind;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          aw;
    int          dw;
    logic [31:0] exp_result;
    logic        exp_err;
    logic [31:0] exp_daddr;
    logic [1:0]  exp_dsize;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic [2:0] k, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input logic [31:0] rt,
                              input logic [31:0] rd, input int aw, input int dw,
                              input logic [31:0] er, input logic ee,
                              input logic [31:0] ea, input logic [1:0] es);
    vec_t v;
    v.write = w; v.kind = k; v.size = sz; v.addr = a; v.wdata = wd; v.strobe = st;
    v.rt = rt; v.rdata = rd; v.aw = aw; v.dw = dw; v.exp_result = er; v.exp_err = ee;
    v.exp_daddr = ea; v.exp_dsize = es;
    return v;
  endfunction

  // scoreboard check
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one memory op, with the bench acting as bus agent
  task automatic run_vec(input vec_t v, input bit flush_in_addr);
    logic [3:0] exp_strobe;
    exp_strobe = v.write ? v.strobe : 4'd0;
    @(negedge clk);
    req_valid = 1'b1; req_write = v.write; req_ld_kind = v.kind; req_size = v.size;
    req_addr = v.addr; req_wdata = v.wdata; req_strobe = v.strobe; req_rt_old = v.rt;
    #1 chk("stall_on_req", {31'd0, stall}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.exp_err) begin
      chk("err_no_dreq", {31'd0, dreq_valid}, 32'd0);
    end else begin
      chk("dreq_valid", {31'd0, dreq_valid}, 32'd1);
      chk("dreq_addr", dreq_addr, v.exp_daddr);
      chk("dreq_size", {30'd0, dreq_size}, {30'd0, v.exp_dsize});
      chk("dreq_strobe", {28'd0, dreq_strobe}, {28'd0, exp_strobe});
      if (v.write) chk("dreq_data", dreq_data, v.wdata);
      chk("stall_addr", {31'd0, stall}, 32'd1);
      for (int i = 0; i < v.aw; i++) begin
        if (flush_in_addr && i == 0) flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("wait_dreq_valid", {31'd0, dreq_valid}, 32'd1);
        chk("wait_dreq_addr", dreq_addr, v.exp_daddr);
        chk("wait_dreq_size", {30'd0, dreq_size}, {30'd0, v.exp_dsize});
        chk("wait_stall", {31'd0, stall}, 32'd1);
      end
      dresp_addr_ok = 1'b1;
      if (v.dw == 0) begin
        dresp_data_ok = 1'b1;
        dresp_data    = v.rdata;
      end
      @(negedge clk);
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = GARBAGE;
      for (int i = 0; i < v.dw; i++) begin
        chk("data_dreq_drop", {31'd0, dreq_valid}, 32'd0);
        chk("data_stall", {31'd0, stall}, 32'd1);
        chk("data_no_rv", {31'd0, result_valid}, 32'd0);
        if (i == v.dw - 1) begin
          dresp_data_ok = 1'b1;
          dresp_data    = v.rdata;
        end
        @(negedge clk);
        dresp_data_ok = 1'b0; dresp_data = GARBAGE;
      end
    end
    chk("done_state", {30'd0, dbg_state}, 32'd3);
    chk("done_rv", {31'd0, result_valid}, flush_in_addr ? 32'd0 : 32'd1);
    chk("done_err", {31'd0, addr_err}, {31'd0, v.exp_err});
    chk("done_stall", {31'd0, stall}, 32'd0);
    if (!flush_in_addr) chk("done_result", result, v.exp_result);
    @(negedge clk);
    chk("rv_pulse", {31'd0, result_valid}, 32'd0);
    chk("err_pulse", {31'd0, addr_err}, 32'd0);
    if (!flush_in_addr) chk("result_hold", result, v.exp_result);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_ld_kind = 3'd0; req_size = 2'd0;
    req_addr = '0; req_wdata = '0; req_strobe = '0; req_rt_old = '0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = GARBAGE;

    //          w  kind  sz  addr          wdata         stb   rt            rdata         aw dw  exp_result    err  exp_daddr     dsz
    vecs.push_back(mk(0, 3'd0, 2'd2, 32'h0000_0100, 32'h0,        4'h0, 32'h0,        32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 0, 32'h0000_0100, 2'd2));
    vecs.push_back(mk(0, 3'd1, 2'd0, 32'h0000_0103, 32'h0,        4'h0, 32'h0,        32'h8011_2233, 0, 0, 32'hFFFF_FF80, 0, 32'h0000_0103, 2'd0));
    vecs.push_back(mk(0, 3'd2, 2'd0, 32'h0000_0103, 32'h0,        4'h0, 32'h0,        32'h8011_2233, 0, 0, 32'h0000_0080, 0, 32'h0000_0103, 2'd0));
    vecs.push_back(mk(0, 3'd3, 2'd1, 32'h0000_0102, 32'h0,        4'h0, 32'h0,        32'h8011_2233, 0, 0, 32'hFFFF_8011, 0, 32'h0000_0102, 2'd1));
    vecs.push_back(mk(0, 3'd4, 2'd1, 32'h0000_0102, 32'h0,        4'h0, 32'h0,        32'h8011_2233, 0, 1, 32'h0000_8011, 0, 32'h0000_0102, 2'd1));
    vecs.push_back(mk(0, 3'd5, 2'd0, 32'h0000_0201, 32'h0,        4'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 32'h3344_CCDD, 0, 32'h0000_0200, 2'd2));
    vecs.push_back(mk(0, 3'd6, 2'd1, 32'h0000_0202, 32'h0,        4'h0, 32'hAABB_CCDD, 32'h1122_3344, 1, 0, 32'hAABB_1122, 0, 32'h0000_0200, 2'd2));
    vecs.push_back(mk(0, 3'd5, 2'd2, 32'h0000_0203, 32'h0,        4'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 32'h1122_3344, 0, 32'h0000_0200, 2'd2));
    vecs.push_back(mk(0, 3'd6, 2'd2, 32'h0000_0203, 32'h0,        4'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 32'hAABB_CC11, 0, 32'h0000_0200, 2'd2));
    vecs.push_back(mk(0, 3'd5, 2'd2, 32'h0000_0200, 32'h0,        4'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 32'h44BB_CCDD, 0, 32'h0000_0200, 2'd2));
    vecs.push_back(mk(0, 3'd1, 2'd0, 32'h0000_0101, 32'h0,        4'h0, 32'h0,        32'h8011_2233, 0, 0, 32'h0000_0022, 0, 32'h0000_0101, 2'd0));
    vecs.push_back(mk(0, 3'd3, 2'd1, 32'h0000_0100, 32'h0,        4'h0, 32'h0,        32'h1234_F00D, 0, 0, 32'hFFFF_F00D, 0, 32'h0000_0100, 2'd1));
    vecs.push_back(mk(0, 3'd0, 2'd2, 32'h0000_0104, 32'h0,        4'h0, 32'h0,        32'h0BAD_F00D, 3, 2, 32'h0BAD_F00D, 0, 32'h0000_0104, 2'd2));
    vecs.push_back(mk(1, 3'd0, 2'd2, 32'h0000_0300, 32'hCAFE_BABE, 4'hF, 32'h0,        32'h1111_1111, 1, 1, 32'h0000_0000, 0, 32'h0000_0300, 2'd2));
    vecs.push_back(mk(0, 3'd0, 2'd2, 32'h0000_0108, 32'h0,        4'h0, 32'h0,        32'h7777_0001, 0, 0, 32'h7777_0001, 0, 32'h0000_0108, 2'd2));
    vecs.push_back(mk(1, 3'd0, 2'd0, 32'h0000_0301, 32'h0000_AB00, 4'h2, 32'h0,        32'h2222_2222, 0, 0, 32'h0000_0000, 0, 32'h0000_0301, 2'd0));
    vecs.push_back(mk(0, 3'd3, 2'd1, 32'h0000_0101, 32'h0,        4'h0, 32'h0,        32'h0,        0, 0, 32'h0000_0000, 1, 32'h0,        2'd0));
    vecs.push_back(mk(0, 3'd0, 2'd2, 32'h0000_0102, 32'h0,        4'h0, 32'h0,        32'h0,        0, 0, 32'h0000_0000, 1, 32'h0,        2'd0));
    vecs.push_back(mk(1, 3'd0, 2'd1, 32'h0000_0303, 32'h1234_0000, 4'hC, 32'h0,        32'h0,        0, 0, 32'h0000_0000, 1, 32'h0,        2'd0));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_dreq_valid", {31'd0, dreq_valid}, 32'd0);
    chk("rst_dreq_addr", dreq_addr, 32'd0);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      // a nonzero result before each misaligned op makes its zeroed result observable
      if (vecs[i].exp_err) run_vec(vecs[14], 1'b0);
      run_vec(vecs[i], 1'b0);
    end

    // flush in ADDR: bus still completes, result suppressed, next op normal
    run_vec(mk(0, 3'd0, 2'd2, 32'h0000_0400, 32'h0, 4'h0, 32'h0, 32'h4444_5555, 2, 1,
               32'h4444_5555, 0, 32'h0000_0400, 2'd2), 1'b1);
    run_vec(vecs[0], 1'b0);

    // flush in IDLE blocks latching of that cycle's request
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_ld_kind = 3'd0; req_size = 2'd2;
    req_addr = 32'h0000_0500; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_state", {30'd0, dbg_state}, 32'd0);
    chk("idle_flush_dreq", {31'd0, dreq_valid}, 32'd0);
    chk("idle_flush_rv", {31'd0, result_valid}, 32'd0);

    // reset asserted while waiting in DATA clears everything at once
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_ld_kind = 3'd0; req_size = 2'd2;
    req_addr = 32'h0000_0600;
    @(negedge clk);
    req_valid = 1'b0; dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    chk("pre_rst_state", {30'd0, dbg_state}, 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("mid_rst_dreq_valid", {31'd0, dreq_valid}, 32'd0);
    chk("mid_rst_dreq_addr", dreq_addr, 32'd0);
    chk("mid_rst_dreq_size", {30'd0, dreq_size}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_rv", {31'd0, result_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[3], 1'b0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage data-bus controller that sits directly downstream of the store-data alignment logic.
- Takes one memory operation per instruction: already-aligned store data and strobe, or a load kind plus the old rt value.
- Drives the data-bus request, holds it until the address handshake, waits for read data, and extracts or sign-extends the load result for writeback, including LWL/LWR merging.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed at 32; other values unsupported)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  memory op present in stage this cycle
req_write  in  1  1 = store, 0 = load
req_ld_kind  in  3  load kind: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR
req_size  in  2  access size: 0 = 1B, 1 = 2B, 2 = 4B
req_addr  in  32  byte address
req_wdata  in  32  lane-aligned store data
req_strobe  in  4  byte write enables
req_rt_old  in  32  current rt value, used for LWL/LWR merge
flush  in  1  kill the in-flight op's result (exception or redirect)
stall  out  1  hold upstream stages
result_valid  out  1  one-cycle completion pulse
result  out  32  extracted load value; 0 for stores
addr_err  out  1  misaligned access, qualified by result_valid
dreq_valid  out  1  bus request valid
dreq_addr  out  32  bus request address
dreq_size  out  2  bus request size
dreq_strobe  out  4  bus write strobes; 0 for loads
dreq_data  out  32  bus write data
dresp_addr_ok  in  1  request accepted
dresp_data_ok  in  1  response or data returned
dresp_data  in  32  read data (full word)

Behaviour:
- States: IDLE, ADDR, DATA, DONE.
- Reset values (immediate, asynchronous):
  - state = IDLE.
  - All dreq_* outputs = 0.
  - result_valid = 0, result = 0, addr_err = 0, killed = 0.
- IDLE:
  - On req_valid, latch all req_* into registers.
  - stall is combinationally 1 in that cycle.
  - Misalignment check: size 1 with addr[0] = 1, or size 2 with addr[1:0] != 0, excluding LWL/LWR.
  - If misaligned: go to DONE with addr_err = 1; no bus request is issued.
  - Otherwise go to ADDR.
- dreq_* outputs are driven from the latched registers only.
  - dreq_valid = 1 exactly while in ADDR.
  - dreq_addr is forced word-aligned for LWL/LWR; for all other ops it is req_addr unchanged.
  - LWL/LWR force dreq_size = 2.
- ADDR:
  - Wait for dresp_addr_ok.
  - dreq_valid and every dreq_* field must stay stable until addr_ok, even if flush is asserted.
  - addr_ok without data_ok: go to DATA.
  - addr_ok and data_ok in the same cycle: capture dresp_data and go to DONE.
- DATA: on data_ok, capture dresp_data and go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - result_valid = 1 unless killed; stall = 0.
  - Next state is IDLE.
  - Latency for a load with zero-wait handshakes: req_valid at cycle 0, dreq_valid at cycle 1, result_valid at cycle 2.
- stall = 1 in ADDR and DATA, and in IDLE when req_valid = 1.
- flush behaviour:
  - A flush in any non-IDLE state sets killed.
  - The transaction still completes on the bus, but result_valid is suppressed in DONE.
  - killed clears on entry to IDLE.
  - A flush in IDLE prevents that cycle's request from being latched.
- Load extraction, with o = addr[1:0] and d = captured data:
  - LB / LBU: byte d[8o+7:8o], sign- or zero-extended.
  - LH / LHU: half d[16·o[1]+15 : 16·o[1]], sign- or zero-extended.
  - LW: d.
  - LWL: o = 3 → d; o = 2 → {d[23:0], rt[7:0]}; o = 1 → {d[15:0], rt[15:0]}; o = 0 → {d[7:0], rt[23:0]}.
  - LWR: o = 0 → d; o = 1 → {rt[31:24], d[31:8]}; o = 2 → {rt[31:16], d[31:16]}; o = 3 → {rt[31:8], d[31:24]}.
  - Stores: result = 0.
- result holds its value until the next DONE.
- Reset asserted mid-transaction returns to IDLE immediately and drops dreq_valid. The bus agent is reset in the same domain.

Test Plan:
- LW: addr 0x100, addr_ok and data_ok same cycle, data 0xDEADBEEF → dreq_valid at cycle 1, result 0xDEADBEEF with result_valid at cycle 2, stall high in cycles 0–1.
- LB: addr 0x103, data 0x80112233 → result 0xFFFFFF80. Repeat as LBU → result 0x00000080. LH at 0x102 with same data → result 0xFFFF8011.
- LWL/LWR: rt_old 0xAABBCCDD, data 0x11223344. LWL at o = 1 → result 0x3344CCDD. LWR at o = 2 → result 0xAABB1122. dreq_addr low bits = 00 in both.
- Wait states: addr_ok delayed 3 cycles, then data_ok delayed 2 more → dreq_* stable throughout ADDR, stall held, exactly one result_valid pulse.
- Flush in ADDR: dreq_valid stays asserted until addr_ok, transaction completes, result_valid stays 0, and the next request is accepted normally.
- Misaligned LH at 0x101 → no dreq_valid, result_valid = 1 with addr_err = 1 one cycle later. Reset asserted in DATA → all outputs 0 immediately.
